// File: rtl/gyro_integrator.sv
// +----------------------------------------------------------------------------+
// | gyro_integrator: multi-channel rate-to-angle integrator with bias cal.     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module gyro_integrator #(
  parameter int NCH      = 3,
  parameter int IN_W     = 16,
  parameter int ACC_W    = 32,
  parameter int PERIOD   = 100000,
  parameter int SHIFT    = 10,
  parameter int WRAP     = 1,
  parameter int CAL_LOG2 = 4
) (
  input  logic                   clk_100mhz,
  input  logic                   rst_n_in,
  input  logic                   sample_valid_in,
  input  logic [NCH*IN_W-1:0]    sample_in,
  input  logic                   cal_start_in,
  input  logic                   zero_in,
  output logic [NCH*ACC_W-1:0]   angle_out,
  output logic                   valid_out,
  output logic                   stale_out,
  output logic                   cal_busy_out,
  output logic                   cal_done_out
);

  localparam int CNT_W  = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int SUM_W  = IN_W + CAL_LOG2;
  localparam int CCNT_W = CAL_LOG2 + 1;

  localparam logic [CNT_W-1:0]        TICK_LAST = CNT_W'(PERIOD - 1);
  localparam logic [CCNT_W-1:0]       CAL_LAST  = CCNT_W'((1 << CAL_LOG2) - 1);
  localparam logic signed [ACC_W-1:0] ACC_MAX   = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN   = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic {
    ST_RUN = 1'b0,
    ST_CAL = 1'b1
  } state_t;

  state_t                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [CCNT_W-1:0]         cal_cnt_q, cal_cnt_d;
  logic [NCH*IN_W-1:0]       hold_q, hold_d;
  logic                      fresh_q, fresh_d;
  logic                      valid_q, valid_d;
  logic                      stale_q, stale_d;
  logic                      done_q, done_d;
  logic signed [IN_W-1:0]    bias_q  [NCH];
  logic signed [IN_W-1:0]    bias_d  [NCH];
  logic signed [SUM_W-1:0]   sum_q   [NCH];
  logic signed [SUM_W-1:0]   sum_d   [NCH];
  logic signed [ACC_W-1:0]   angle_q [NCH];
  logic signed [ACC_W-1:0]   angle_d [NCH];

  logic                      tick;
  logic [NCH*IN_W-1:0]       sample_eff;
  logic signed [ACC_W-1:0]   angle_nx [NCH];
  logic signed [SUM_W-1:0]   sum_nx   [NCH];
  logic signed [IN_W-1:0]    bias_nx  [NCH];

  assign tick       = (cnt_q == TICK_LAST);
  // A sample arriving on the tick cycle itself wins over the held one.
  assign sample_eff = sample_valid_in ? sample_in : hold_q;

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    logic signed [IN_W-1:0]  samp;
    logic signed [IN_W:0]    diff;
    logic signed [IN_W:0]    shifted;
    logic signed [ACC_W-1:0] delta;
    logic signed [ACC_W:0]   wide;
    logic                    ovf;

    assign samp    = sample_eff[k*IN_W +: IN_W];
    assign diff    = {samp[IN_W-1], samp} - {bias_q[k][IN_W-1], bias_q[k]};
    assign shifted = diff >>> SHIFT;
    assign delta   = ACC_W'(shifted);
    assign wide    = {angle_q[k][ACC_W-1], angle_q[k]} + {delta[ACC_W-1], delta};
    assign ovf     = wide[ACC_W] ^ wide[ACC_W-1];

    assign angle_nx[k] = (WRAP == 0 && ovf) ? (wide[ACC_W] ? ACC_MIN : ACC_MAX)
                                            : wide[ACC_W-1:0];
    assign sum_nx[k]   = sum_q[k] + SUM_W'(samp);
    assign bias_nx[k]  = IN_W'(sum_nx[k] >>> CAL_LOG2);

    assign angle_out[k*ACC_W +: ACC_W] = angle_q[k];
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = tick ? '0 : cnt_q + CNT_W'(1);
    cal_cnt_d = cal_cnt_q;
    hold_d    = hold_q;
    fresh_d   = fresh_q;
    valid_d   = 1'b0;
    stale_d   = 1'b0;
    done_d    = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      bias_d[k]  = bias_q[k];
      sum_d[k]   = sum_q[k];
      angle_d[k] = angle_q[k];
    end

    if (sample_valid_in) begin
      hold_d  = sample_in;
      fresh_d = 1'b1;
    end
    if (tick) begin
      fresh_d = 1'b0;
    end

    case (state_q)
      ST_RUN: begin
        if (tick) begin
          valid_d = 1'b1;
          stale_d = ~(sample_valid_in | fresh_q);
          for (int k = 0; k < NCH; k++) begin
            angle_d[k] = angle_nx[k];
          end
        end
        if (cal_start_in) begin
          state_d   = ST_CAL;
          cnt_d     = '0;
          cal_cnt_d = '0;
          for (int k = 0; k < NCH; k++) begin
            sum_d[k] = '0;
          end
        end
      end
      ST_CAL: begin
        if (tick) begin
          cal_cnt_d = cal_cnt_q + CCNT_W'(1);
          for (int k = 0; k < NCH; k++) begin
            sum_d[k] = sum_nx[k];
          end
          if (cal_cnt_q == CAL_LAST) begin
            state_d = ST_RUN;
            done_d  = 1'b1;
            for (int k = 0; k < NCH; k++) begin
              bias_d[k] = bias_nx[k];
            end
          end
        end
      end
      default: state_d = ST_RUN;
    endcase

    if (zero_in) begin
      valid_d = 1'b0;
      stale_d = 1'b0;
      for (int k = 0; k < NCH; k++) begin
        angle_d[k] = '0;
      end
    end
  end

  always_ff @(posedge clk_100mhz or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q   <= ST_RUN;
      cnt_q     <= '0;
      cal_cnt_q <= '0;
      hold_q    <= '0;
      fresh_q   <= 1'b0;
      valid_q   <= 1'b0;
      stale_q   <= 1'b0;
      done_q    <= 1'b0;
      for (int k = 0; k < NCH; k++) begin
        bias_q[k]  <= '0;
        sum_q[k]   <= '0;
        angle_q[k] <= '0;
      end
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cal_cnt_q <= cal_cnt_d;
      hold_q    <= hold_d;
      fresh_q   <= fresh_d;
      valid_q   <= valid_d;
      stale_q   <= stale_d;
      done_q    <= done_d;
      for (int k = 0; k < NCH; k++) begin
        bias_q[k]  <= bias_d[k];
        sum_q[k]   <= sum_d[k];
        angle_q[k] <= angle_d[k];
      end
    end
  end

  assign valid_out    = valid_q;
  assign stale_out    = stale_q;
  assign cal_done_out = done_q;
  assign cal_busy_out = (state_q == ST_CAL);

endmodule

`default_nettype wire
